// File: rtl/i2cs_core.sv
// I2C target exposing a 16 x 8 register bank to an I2C master and to a reg-bus port.
// The pads are sampled through 2 synchronizer flops plus 1 edge flop. The reg-bus acks after 1 cycle and SCL is never stretched.
module i2cs_core (
   input  logic       app_clk,
   input  logic       reset_n,
   input  logic       cfg_en,
   input  logic [6:0] cfg_slv_addr,
   input  logic       scl_pad_i,
   output logic       scl_pad_o,
   output logic       scl_padoen_o,
   input  logic       sda_pad_i,
   output logic       sda_pad_o,
   output logic       sda_padoen_o,
   input  logic       reg_cs,
   input  logic       reg_wr,
   input  logic [3:0] reg_addr,
   input  logic [7:0] reg_wdata,
   output logic [7:0] reg_rdata,
   output logic       reg_ack,
   output logic       i2cs_wr_intr_o
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] scl_sr, sda_sr;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [3:0] ptr, ptr_nxt;
   logic       rw, rw_nxt;
   logic       wr_flag, wr_flag_nxt;
   logic       sda_oe, sda_oe_nxt;
   logic       intr_nxt;
   logic       i2c_we;
   logic [7:0] i2c_wdat;
   logic [7:0] bank [16];
   logic [7:0] ptr_byte;
   logic       scl_rise, scl_fall, start_det, stop_det, sda_in;
   logic       reg_we, reg_re;

   assign scl_pad_o    = 1'b0;
   assign sda_pad_o    = 1'b0;
   assign scl_padoen_o = 1'b1;
   assign sda_padoen_o = sda_oe;

   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         scl_sr <= 3'b111;
         sda_sr <= 3'b111;
      end else begin
         scl_sr <= {scl_sr[1:0], scl_pad_i};
         sda_sr <= {sda_sr[1:0], sda_pad_i};
      end
   end

   assign sda_in    = sda_sr[1];
   assign scl_rise  = scl_sr[1] & ~scl_sr[2];
   assign scl_fall  = ~scl_sr[1] & scl_sr[2];
   assign start_det = scl_sr[1] & scl_sr[2] & ~sda_sr[1] & sda_sr[2];
   assign stop_det  = scl_sr[1] & scl_sr[2] & sda_sr[1] & ~sda_sr[2];
   assign ptr_byte  = bank[ptr];

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      shreg_nxt   = shreg;
      ptr_nxt     = ptr;
      rw_nxt      = rw;
      wr_flag_nxt = wr_flag;
      sda_oe_nxt  = sda_oe;
      intr_nxt    = 1'b0;
      i2c_we      = 1'b0;
      i2c_wdat    = {shreg[6:0], sda_in};
      if (!cfg_en) begin
         state_nxt  = IDLE;
         sda_oe_nxt = 1'b1;
      end else if (start_det) begin
         state_nxt   = ADDR;
         cnt_nxt     = 4'd0;
         sda_oe_nxt  = 1'b1;
         wr_flag_nxt = 1'b0;
      end else if (stop_det) begin
         state_nxt   = IDLE;
         sda_oe_nxt  = 1'b1;
         intr_nxt    = wr_flag;
         wr_flag_nxt = 1'b0;
      end else begin
         case (state)
            ADDR, PTR, WDATA: begin
               if (scl_rise && cnt != 4'd8) begin
                  shreg_nxt = {shreg[6:0], sda_in};
                  cnt_nxt   = cnt + 4'd1;
                  if (state == WDATA && cnt == 4'd7) begin
                     i2c_we      = 1'b1;
                     wr_flag_nxt = 1'b1;
                  end
               end else if (scl_fall && cnt == 4'd8) begin
                  // the ACK slot starts at the fall after the 8th bit
                  case (state)
                     ADDR: begin
                        if (shreg[7:1] == cfg_slv_addr) begin
                           state_nxt  = ADDR_ACK;
                           sda_oe_nxt = 1'b0;
                           rw_nxt     = shreg[0];
                        end else begin
                           state_nxt = WAIT;
                        end
                     end
                     PTR: begin
                        ptr_nxt    = shreg[3:0];
                        state_nxt  = PTR_ACK;
                        sda_oe_nxt = 1'b0;
                     end
                     default: begin
                        ptr_nxt    = ptr + 4'd1;
                        state_nxt  = WDATA_ACK;
                        sda_oe_nxt = 1'b0;
                     end
                  endcase
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  cnt_nxt = 4'd0;
                  if (rw) begin
                     state_nxt  = RDATA;
                     shreg_nxt  = ptr_byte;
                     sda_oe_nxt = ptr_byte[7];
                  end else begin
                     state_nxt  = PTR;
                     sda_oe_nxt = 1'b1;
                  end
               end
            end
            PTR_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  state_nxt  = WDATA;
                  cnt_nxt    = 4'd0;
                  sda_oe_nxt = 1'b1;
               end
            end
            RDATA: begin
               if (scl_rise) begin
                  cnt_nxt = cnt + 4'd1;
               end else if (scl_fall) begin
                  if (cnt == 4'd8) begin
                     state_nxt  = RDATA_ACK;
                     sda_oe_nxt = 1'b1;
                  end else begin
                     shreg_nxt  = {shreg[6:0], 1'b0};
                     sda_oe_nxt = shreg[6];
                  end
               end
            end
            RDATA_ACK: begin
               if (scl_rise) begin
                  if (sda_in) state_nxt = WAIT;
                  else        ptr_nxt   = ptr + 4'd1;
               end else if (scl_fall) begin
                  state_nxt  = RDATA;
                  cnt_nxt    = 4'd0;
                  shreg_nxt  = ptr_byte;
                  sda_oe_nxt = ptr_byte[7];
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         shreg          <= 8'd0;
         ptr            <= 4'd0;
         rw             <= 1'b0;
         wr_flag        <= 1'b0;
         sda_oe         <= 1'b1;
         i2cs_wr_intr_o <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         shreg          <= shreg_nxt;
         ptr            <= ptr_nxt;
         rw             <= rw_nxt;
         wr_flag        <= wr_flag_nxt;
         sda_oe         <= sda_oe_nxt;
         i2cs_wr_intr_o <= intr_nxt;
      end
   end

   assign reg_we = reg_cs & reg_wr & ~reg_ack;
   assign reg_re = reg_cs & ~reg_wr & ~reg_ack;

   // I2C write is applied last so it wins a same-index collision
   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) bank[i] <= 8'd0;
      end else begin
         if (reg_we) bank[reg_addr] <= reg_wdata;
         if (i2c_we) bank[ptr] <= i2c_wdat;
      end
   end

   always_ff @(posedge app_clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_ack   <= 1'b0;
         reg_rdata <= 8'd0;
      end else begin
         reg_ack <= reg_cs & ~reg_ack;
         if (reg_re) reg_rdata <= (i2c_we && ptr == reg_addr) ? i2c_wdat : bank[reg_addr];
      end
   end

endmodule

// File: tb/tb_i2cs_core.sv
// Bench for i2cs_core: bit-banged I2C master plus reg-bus driver, checked against a byte-level bank/pointer model.
module tb_i2cs_core;

   logic       app_clk = 1'b0;
   logic       reset_n, cfg_en;
   logic [6:0] cfg_slv_addr;
   logic       scl_m, sda_m, scl_line, sda_line;
   logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
   logic       reg_cs, reg_wr, reg_ack, intr;
   logic [3:0] reg_addr;
   logic [7:0] reg_wdata, reg_rdata;

   always #5 app_clk = ~app_clk;

   assign scl_line = scl_m & scl_padoen_o;
   assign sda_line = sda_m & sda_padoen_o;

   i2cs_core dut (
      .app_clk(app_clk), .reset_n(reset_n), .cfg_en(cfg_en), .cfg_slv_addr(cfg_slv_addr),
      .scl_pad_i(scl_line), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
      .sda_pad_i(sda_line), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
      .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_ack(reg_ack), .i2cs_wr_intr_o(intr));

   int n_tests = 0, n_fail = 0;
   int intr_cnt = 0, drive_cnt = 0, dbl_intr = 0, dbl_ack = 0;
   logic intr_q = 1'b0, ack_q = 1'b0;
   logic [7:0] mbank [16];
   int mptr;
   logic [7:0] wbuf [16];

   always @(posedge app_clk) begin
      if (intr === 1'b1) intr_cnt++;
      if (sda_padoen_o === 1'b0) drive_cnt++;
      if (intr === 1'b1 && intr_q) dbl_intr++;
      if (reg_ack === 1'b1 && ack_q) dbl_ack++;
      intr_q = (intr === 1'b1);
      ack_q  = (reg_ack === 1'b1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge app_clk);
      #1;
   endtask

   task automatic reg_op(input logic w, input logic [3:0] a, input logic [7:0] d, output logic [7:0] rd);
      reg_cs = 1'b1; reg_wr = w; reg_addr = a; reg_wdata = d;
      tick(1);
      check("reg_ack_latency", reg_ack, 1);
      rd = reg_rdata;
      reg_cs = 1'b0;
      tick(1);
      check("reg_ack_drop", reg_ack, 0);
   endtask

   task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
      logic [7:0] rd;
      reg_op(1'b1, a, d, rd);
      mbank[a] = d;
   endtask

   task automatic reg_read_chk(input string nm, input logic [3:0] a);
      logic [7:0] rd;
      reg_op(1'b0, a, 8'h00, rd);
      check(nm, rd, mbank[a]);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(5); scl_m = 1'b1; tick(5); sda_m = 1'b0; tick(5); scl_m = 1'b0; tick(5);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(5); scl_m = 1'b1; tick(5); sda_m = 1'b1; tick(5);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; tick(5); scl_m = 1'b1; tick(10); scl_m = 1'b0; tick(5);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; tick(5); scl_m = 1'b1; tick(5); b = sda_line; tick(5); scl_m = 1'b0; tick(5);
   endtask

   task automatic write_byte(input logic [7:0] v, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(output logic [7:0] v, input logic last);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         v[i] = b;
      end
      send_bit(last);
   endtask

   task automatic i2c_write_tx(input logic [3:0] p, input int n);
      logic ack;
      int i0;
      i0 = intr_cnt;
      i2c_start();
      write_byte(8'h54, ack); check("wr_addr_ack", ack, 1);
      write_byte({4'h0, p}, ack); check("wr_ptr_ack", ack, 1);
      for (int i = 0; i < n; i++) begin
         write_byte(wbuf[i], ack); check("wr_data_ack", ack, 1);
         mbank[(int'(p) + i) & 15] = wbuf[i];
      end
      i2c_stop();
      tick(3);
      mptr = (int'(p) + n) & 15;
      check("wr_intr_count", intr_cnt - i0, (n > 0) ? 1 : 0);
   endtask

   task automatic i2c_read_tx(input logic [3:0] p, input int n);
      logic ack;
      logic [7:0] d;
      int i0;
      i0 = intr_cnt;
      i2c_start();
      write_byte(8'h54, ack); check("rd_addr_w_ack", ack, 1);
      write_byte({4'h0, p}, ack); check("rd_ptr_ack", ack, 1);
      i2c_start();
      write_byte(8'h55, ack); check("rd_addr_r_ack", ack, 1);
      for (int i = 0; i < n; i++) begin
         read_byte(d, i == n - 1);
         check("rd_data", d, mbank[(int'(p) + i) & 15]);
      end
      i2c_stop();
      tick(3);
      mptr = (int'(p) + n - 1) & 15;
      check("rd_no_intr", intr_cnt - i0, 0);
   endtask

   // drives the reg-bus write into the exact cycle the I2C byte commits
   task automatic collide(input logic [3:0] ia, input logic [7:0] iv, input logic [3:0] ra, input logic [7:0] rv);
      logic ack, b;
      i2c_start();
      write_byte(8'h54, ack);
      write_byte({4'h0, ia}, ack);
      for (int i = 7; i >= 1; i--) send_bit(iv[i]);
      sda_m = iv[0]; tick(5);
      scl_m = 1'b1; tick(2);
      reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = ra; reg_wdata = rv;
      tick(1);
      check("coll_reg_ack", reg_ack, 1);
      reg_cs = 1'b0;
      tick(7);
      scl_m = 1'b0; tick(5);
      recv_bit(b);
      check("coll_data_ack", b, 0);
      i2c_stop();
      tick(3);
      mbank[ra] = rv;
      mbank[ia] = iv;
      mptr = (int'(ia) + 1) & 15;
   endtask

   typedef struct {
      logic       wr;
      logic [3:0] a;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl [6];

   initial begin
      logic ack;
      logic [7:0] rd;
      int d0, i0;

      tbl[0] = '{1'b0, 4'd7,  8'h00, 8'h00};
      tbl[1] = '{1'b1, 4'd1,  8'h3C, 8'h00};
      tbl[2] = '{1'b1, 4'd14, 8'hE1, 8'h00};
      tbl[3] = '{1'b0, 4'd1,  8'h00, 8'h3C};
      tbl[4] = '{1'b0, 4'd14, 8'h00, 8'hE1};
      tbl[5] = '{1'b0, 4'd15, 8'h00, 8'h00};

      reset_n = 1'b0; cfg_en = 1'b1; cfg_slv_addr = 7'h2A;
      scl_m = 1'b1; sda_m = 1'b1;
      reg_cs = 1'b0; reg_wr = 1'b0; reg_addr = 4'd0; reg_wdata = 8'd0;
      for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
      mptr = 0;
      tick(3);
      reset_n = 1'b1;
      tick(3);
      check("rst_sda_padoen", sda_padoen_o, 1);
      check("rst_scl_padoen", scl_padoen_o, 1);
      check("rst_pads", {sda_pad_o, scl_pad_o}, 0);
      check("rst_rdata", reg_rdata, 0);
      check("rst_ack", reg_ack, 0);
      check("rst_intr", intr, 0);

      for (int i = 0; i < 6; i++) begin
         reg_op(tbl[i].wr, tbl[i].a, tbl[i].d, rd);
         if (tbl[i].wr) mbank[tbl[i].a] = tbl[i].d;
         else check("tbl_read", rd, tbl[i].exp);
      end

      wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
      i2c_write_tx(4'd3, 2);
      check("t1_bank3", mbank[3], 8'hA5);
      reg_read_chk("t1_bank3_reg", 4'd3);
      reg_read_chk("t1_bank4_reg", 4'd4);

      reg_write(4'd15, 8'h11);
      reg_write(4'd0, 8'h22);
      i2c_read_tx(4'd15, 2);

      d0 = drive_cnt; i0 = intr_cnt;
      i2c_start();
      write_byte(8'h56, ack);
      check("t3_nack", ack, 0);
      i2c_stop();
      tick(3);
      check("t3_no_drive", drive_cnt - d0, 0);
      check("t3_no_intr", intr_cnt - i0, 0);
      reg_read_chk("t3_bank3", 4'd3);

      i0 = intr_cnt;
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h06, ack);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      i2c_stop();
      tick(3);
      mptr = 6;
      check("t4_released", sda_padoen_o, 1);
      check("t4_no_intr", intr_cnt - i0, 0);
      reg_read_chk("t4_bank6", 4'd6);
      i2c_start();
      write_byte(8'h54, ack);
      check("t4_restart_ack", ack, 1);
      i2c_stop();
      tick(3);

      collide(4'd2, 8'h77, 4'd2, 8'h88);
      reg_read_chk("t5_same_idx", 4'd2);
      check("t5_bank2_77", mbank[2], 8'h77);
      collide(4'd5, 8'h3C, 4'd7, 8'hC3);
      reg_read_chk("t5_i2c_idx", 4'd5);
      reg_read_chk("t5_reg_idx", 4'd7);

      reg_write(4'd9, 8'h35);
      i2c_start();
      write_byte(8'h54, ack);
      write_byte(8'h09, ack);
      i2c_start();
      write_byte(8'h55, ack);
      check("t6_rd_driving", sda_padoen_o, 0);
      cfg_en = 1'b0;
      tick(1);
      check("t6_cfg_release", sda_padoen_o, 1);
      cfg_en = 1'b1;
      tick(2);
      i2c_stop();
      tick(3);
      mptr = 9;
      i2c_read_tx(4'd9, 1);

      i2c_start();
      for (int i = 7; i >= 0; i--) send_bit(i[0] ? 1'b0 : 1'b1);
      sda_m = 1'b1;
      tick(5);
      check("t6_ack_drive", sda_padoen_o, 0);
      #2 reset_n = 1'b0;
      #1;
      check("t6_rst_sda", sda_padoen_o, 1);
      check("t6_rst_outs", {scl_padoen_o, sda_pad_o, scl_pad_o, reg_ack, intr}, 5'b10000);
      check("t6_rst_rdata", reg_rdata, 0);
      scl_m = 1'b1;
      tick(2);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) mbank[i] = 8'h00;
      mptr = 0;
      tick(5);
      reg_read_chk("t6_bank_cleared", 4'd3);
      wbuf[0] = 8'hC7;
      i2c_write_tx(4'd12, 1);
      reg_read_chk("t6_post_rst_wr", 4'd12);

      for (int it = 0; it < 8; it++) begin
         int op, n;
         logic [3:0] p, a;
         op = $urandom_range(0, 2);
         p  = 4'($urandom_range(0, 15));
         n  = $urandom_range(1, 3);
         if (op == 0) begin
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
            i2c_write_tx(p, n);
         end else if (op == 1) begin
            i2c_read_tx(p, n);
         end else begin
            a = 4'($urandom_range(0, 15));
            reg_write(a, 8'($urandom_range(0, 255)));
            reg_read_chk("rand_reg", 4'($urandom_range(0, 15)));
         end
      end
      for (int i = 0; i < 16; i++) reg_read_chk("final_bank", 4'(i));

      check("intr_single_cycle", dbl_intr, 0);
      check("ack_not_back_to_back", dbl_ack, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2cs_core.md
# i2cs_core

I2C target (slave) responder: the far end of the I2C master bus, answering a 7-bit address and exposing a 16 x 8-bit register bank. External masters read and write the bank over SCL/SDA; SoC software reads and writes the same bank through the reg-bus slave port. It sits beside the I2C master in the I2C wrapper, sharing the pad-style open-drain signalling: `*_pad_o` is tied 0 and `*_padoen_o` is the active-low enable.

## Interface
- No parameters. Address and enable are run-time configuration.
- `app_clk` in 1: single clock for all logic.
- `reset_n` in 1: reset, asynchronous, active-low.
- `cfg_en` in 1: core enable. 0 forces IDLE and releases SDA.
- `cfg_slv_addr` in 7: target address.
- `scl_pad_i` in 1: SCL line input.
- `scl_pad_o` out 1: constant 0.
- `scl_padoen_o` out 1: constant 1. No clock stretching.
- `sda_pad_i` in 1: SDA line input.
- `sda_pad_o` out 1: constant 0.
- `sda_padoen_o` out 1: 0 drives SDA low, 1 releases it.
- `reg_cs` in 1: reg-bus request.
- `reg_wr` in 1: 1 = write, 0 = read.
- `reg_addr` in 4: bank index.
- `reg_wdata` in 8: write data.
- `reg_rdata` out 8: read data, valid while `reg_ack` = 1.
- `reg_ack` out 1: one-cycle acknowledge.
- `i2cs_wr_intr_o` out 1: one-cycle pulse at STOP when the ended transaction wrote at least one data byte.

## Operation
- **Input conditioning**
  - SCL and SDA each pass a 2-flop synchronizer; the flops reset to 1.
  - A third flop stage provides edge detection.
- **Bus conditions** (on synchronized values)
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge. SDA drive changes only after the SCL falling edge.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
- **Address phase**
  - START (including repeated START) from any state → ADDR; the bit counter clears and `ptr` is kept.
  - ADDR shifts in 8 bits, MSB first: 7-bit address, then R/W.
  - Address mismatch → WAIT (SDA released, ignore the bus until START/STOP).
  - Address match → ADDR_ACK, driving SDA low for the 9th clock.
- **Write (R/W = 0)**
  - ADDR_ACK → PTR. The first byte loads `ptr` from bits [3:0]; bits [7:4] are ignored. PTR_ACK acknowledges it.
  - Each following byte goes through WDATA/WDATA_ACK: `bank[ptr]` is written at the 8th rising edge, the byte is acknowledged, and `ptr` = `ptr` + 1 mod 16.
- **Read (R/W = 1)**
  - At the SCL fall ending ADDR_ACK, `bank[ptr]` loads into the shift register. RDATA drives the bits MSB first: `sda_padoen_o` = bit value.
  - RDATA_ACK releases SDA and samples the master's bit on the 9th rising edge.
  - Master ACK (0): `ptr` + 1 mod 16, reload, stay in RDATA.
  - Master NACK (1): → WAIT.
- **STOP** from any state → IDLE with SDA released. If the write flag is set, pulse `i2cs_wr_intr_o`; the flag clears at START.
- **cfg_en = 0** → IDLE immediately and SDA released; the bank and `ptr` are kept. `reg_*` remains functional.
- **Reg bus**
  - `reg_cs` = 1 with `reg_ack` = 0 → `reg_ack` = 1 next cycle, and the write commits in that ack cycle.
  - `reg_ack` is never asserted on two consecutive cycles.
- **Collision:** an I2C write and a reg-bus write to the same index in the same cycle → the I2C value is stored. Different indices → both are stored.

## Timing
- **Reset values:** `sda_padoen_o` = 1, `scl_padoen_o` = 1, `sda_pad_o` = `scl_pad_o` = 0, `reg_rdata` = 0, `reg_ack` = 0, `i2cs_wr_intr_o` = 0, bank = 0, `ptr` = 0, state = IDLE.
- **Pad-to-detect latency:** 3 `app_clk` cycles.
- **SDA drive latency:** `sda_padoen_o` updates 1 cycle after the detected SCL fall, i.e. ≤ 4 `app_clk` cycles after the pad edge.
- **Clock ratio:** `app_clk` ≥ 16 × SCL (1 MHz SCL at ≥ 16 MHz clock).
- **Reg bus:** `reg_rdata`/`reg_ack` registered, read latency 1 cycle. An I2C write in the cycle before `reg_ack` is visible in `reg_rdata`.
- **Interrupt:** `i2cs_wr_intr_o` is high for exactly 1 cycle, the cycle after STOP is detected.
- **Reset mid-transfer:** SDA is released within the reset assertion (async); after release the core waits in IDLE for START.

## Test plan
- Reset, then `cfg_slv_addr` = 7'h2A, master writes 0x54, 0x03, 0xA5, 0x5A, STOP → all 4 bytes ACKed, `bank[3]` = A5, `bank[4]` = 5A, one `i2cs_wr_intr_o` pulse; reg read of index 4 returns 5A with ack 1 cycle after `reg_cs`.
- Reg-bus writes `bank[15]` = 11 and `bank[0]` = 22; master writes 0x54, 0x0F, repeated START, 0x55, reads 2 bytes (ACK, NACK), STOP → read data 11 then 22 (`ptr` wrap), no interrupt.
- Master sends 0x56 (address 7'h2B) → no ACK, SDA stays released through the byte and STOP, bank unchanged.
- STOP after the 4th data bit of a write → IDLE, SDA released, no bank write, no interrupt; the next START + 0x54 is ACKed.
- Same-cycle I2C write and reg write to index 2 (I2C 0x77, reg 0x88) → `bank[2]` = 77.
- `cfg_en` deasserted during a read byte → SDA released within 1 cycle; `reset_n` pulsed mid-write → all outputs return to reset values.
